// File: rtl/isa_pkg.sv
// ---------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the 16-bit ISA execute path: opcode values, the
// ALU opcodes driven towards the external ALU, the controller state enum,
// instruction field positions, the condition-code reset value and the
// sign-extension helpers used for immediates and branch offsets.
// ---------------------------------------------------------------------------
package isa_pkg;

  // Primary opcodes, instruction bits [15:12]
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_CMP  = 4'h4;
  localparam logic [3:0] OP_LDI  = 4'h5;
  localparam logic [3:0] OP_BR   = 4'h6;
  localparam logic [3:0] OP_HALT = 4'h7;

  // Operation codes understood by the external ALU
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_CMP = 4'b0100;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HALT = 2'd2
  } state_t;

  // Instruction field positions
  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 9;
  localparam int RS1_MSB  = 8;
  localparam int RS1_LSB  = 6;
  localparam int IMM_BIT  = 5;
  localparam int IMM5_MSB = 4;
  localparam int RS2_MSB  = 2;
  localparam int OFF9_MSB = 8;

  // Condition code {N,Z,P} after reset: Z set
  localparam logic [2:0] CC_RESET = 3'b010;

  // Two's-complement widening of the 5-bit ALU immediate
  function automatic logic [15:0] sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  // Two's-complement widening of the 9-bit LDI immediate / branch offset
  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

endpackage

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
// 8 x 16 general-purpose register file, R0..R7 all writable.
// Two combinational read ports, one synchronous write port, async reset
// clearing every register.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_we                write enable for this cycle's rising edge
//   i_waddr, i_wdata    write address / data
//   i_raddr1, o_rdata1  read port 1
//   i_raddr2, o_rdata2  read port 2
// ---------------------------------------------------------------------------
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [2:0]  i_waddr,
  input  logic [15:0] i_wdata,
  input  logic [2:0]  i_raddr1,
  output logic [15:0] o_rdata1,
  input  logic [2:0]  i_raddr2,
  output logic [15:0] o_rdata2
);

  logic [15:0] r_mem [8];

  // Storage: cleared on reset, one register written per enabled edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reads are purely combinational; a write is seen from the next cycle on
  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/exec_ctrl.sv
// ---------------------------------------------------------------------------
// exec_ctrl
// Two-cycle execute controller. Accepts an instruction in IDLE, drives the
// external ALU from the latched instruction during EXEC and commits the
// register write-back, condition code and PC on the edge that closes EXEC.
// HALT parks the controller until reset.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   instr_valid/instr_ready      instruction handshake
//   instr                        instruction word
//   pc                           address of the next instruction to fetch
//   alu_a, alu_b, alu_op         operands / opcode towards the ALU
//   alu_result, alu_n/z/p        result and flags back from the ALU
//   cc                           condition code {N,Z,P}
//   illegal                      one-cycle pulse after an undefined opcode
//   halted                       sticky, set once HALT has executed
// ---------------------------------------------------------------------------
module exec_ctrl
  import isa_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [15:0] pc,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_result,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_p,
  output logic [2:0]  cc,
  output logic        illegal,
  output logic        halted
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_ir;
  logic [15:0] r_pc;
  logic [2:0]  r_cc;
  logic        r_illegal;
  logic        r_halted;

  logic [3:0]  w_opc;
  logic [2:0]  w_rd;
  logic [2:0]  w_rs1;
  logic [2:0]  w_rs2;
  logic [15:0] w_rdata1;
  logic [15:0] w_rdata2;
  logic [15:0] w_imm5;
  logic [15:0] w_off9;

  logic [15:0] w_alu_a;
  logic [15:0] w_alu_b;
  logic [3:0]  w_alu_op;
  logic        w_we;
  logic        w_cc_we;
  logic [15:0] w_pc_nxt;
  logic        w_illegal_nxt;
  logic        w_halt_set;

  // Field decode of the latched instruction
  assign w_opc  = r_ir[OPC_MSB:OPC_LSB];
  assign w_rd   = r_ir[RD_MSB:RD_LSB];
  assign w_rs1  = r_ir[RS1_MSB:RS1_LSB];
  assign w_rs2  = r_ir[RS2_MSB:0];
  assign w_imm5 = sext5(r_ir[IMM5_MSB:0]);
  assign w_off9 = sext9(r_ir[OFF9_MSB:0]);

  // Write-back always takes the ALU result into R[rd]; w_we gates it
  regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_we),
    .i_waddr  (w_rd),
    .i_wdata  (alu_result),
    .i_raddr1 (w_rs1),
    .o_rdata1 (w_rdata1),
    .i_raddr2 (w_rs2),
    .o_rdata2 (w_rdata2)
  );

  // Next-state and EXEC datapath control. The ALU ports rest at zero except
  // while an ALU-using instruction is in EXEC.
  always_comb begin
    w_state_nxt   = r_state;
    w_alu_a       = '0;
    w_alu_b       = '0;
    w_alu_op      = '0;
    w_we          = 1'b0;
    w_cc_we       = 1'b0;
    w_pc_nxt      = r_pc;
    w_illegal_nxt = 1'b0;
    w_halt_set    = 1'b0;
    case (r_state)
      IDLE: begin
        if (instr_valid) begin
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_state_nxt = IDLE;
        w_pc_nxt    = r_pc + 16'd1;
        case (w_opc)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            w_alu_a  = w_rdata1;
            w_alu_b  = r_ir[IMM_BIT] ? w_imm5 : w_rdata2;
            w_alu_op = w_opc;
            w_we     = 1'b1;
            w_cc_we  = 1'b1;
          end
          OP_CMP: begin
            w_alu_a  = w_rdata1;
            w_alu_b  = r_ir[IMM_BIT] ? w_imm5 : w_rdata2;
            w_alu_op = ALU_CMP;
            w_cc_we  = 1'b1;
          end
          OP_LDI: begin
            w_alu_b  = w_off9;
            w_alu_op = ALU_ADD;
            w_we     = 1'b1;
            w_cc_we  = 1'b1;
          end
          OP_BR: begin
            // nzp mask sits in the rd field
            if ((w_rd & r_cc) != 3'b000) begin
              w_pc_nxt = r_pc + 16'd1 + w_off9;
            end
          end
          OP_HALT: begin
            w_pc_nxt    = r_pc;
            w_state_nxt = HALT;
            w_halt_set  = 1'b1;
          end
          default: begin
            w_illegal_nxt = 1'b1;
          end
        endcase
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Architectural state. Everything commits on the edge that closes EXEC,
  // so a reset during EXEC discards the instruction entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ir      <= '0;
      r_pc      <= RESET_PC;
      r_cc      <= CC_RESET;
      r_illegal <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_illegal <= w_illegal_nxt;
      if (r_state == IDLE && instr_valid) begin
        r_ir <= instr;
      end
      if (r_state == EXEC) begin
        r_pc <= w_pc_nxt;
      end
      if (w_cc_we) begin
        r_cc <= {alu_n, alu_z, alu_p};
      end
      if (w_halt_set) begin
        r_halted <= 1'b1;
      end
    end
  end

  // Ready follows the state register only, never instr_valid
  assign instr_ready = (r_state == IDLE);
  assign pc          = r_pc;
  assign cc          = r_cc;
  assign illegal     = r_illegal;
  assign halted      = r_halted;
  assign alu_a       = w_alu_a;
  assign alu_b       = w_alu_b;
  assign alu_op      = w_alu_op;

endmodule

// File: tb/tb_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_exec_ctrl
// Self-checking bench for exec_ctrl with a behavioural ALU attached. An ISA
// reference model predicts ALU operands (queued at issue, compared in the
// EXEC cycle), and pc / cc / illegal / halted after each instruction.
// ---------------------------------------------------------------------------
module tb_exec_ctrl;

  logic        clk;
  logic        rst;
  logic        instrValid;
  logic        instrReady;
  logic [15:0] instrWord;
  logic [15:0] pcOut;
  logic [15:0] aluA;
  logic [15:0] aluB;
  logic [3:0]  aluOp;
  logic [15:0] aluRes;
  logic        aluN;
  logic        aluZ;
  logic        aluP;
  logic [2:0]  ccOut;
  logic        illegalOut;
  logic        haltedOut;

  int checksTotal  = 0;
  int checksPassed = 0;

  typedef struct {
    logic        chk;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  sbEntry_t monEntry;

  logic [15:0] modelR [8];
  logic [15:0] modelPc;
  logic [2:0]  modelCc;

  exec_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instrValid),
    .instr_ready (instrReady),
    .instr       (instrWord),
    .pc          (pcOut),
    .alu_a       (aluA),
    .alu_b       (aluB),
    .alu_op      (aluOp),
    .alu_result  (aluRes),
    .alu_n       (aluN),
    .alu_z       (aluZ),
    .alu_p       (aluP),
    .cc          (ccOut),
    .illegal     (illegalOut),
    .halted      (haltedOut)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: CMP computes a - b for its flags
  function automatic logic [15:0] aluCalc(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a - b;
      default: return 16'h0000;
    endcase
  endfunction

  // Flags {N,Z,P} of a result
  function automatic logic [2:0] nzpOf(input logic [15:0] r);
    if (r[15])         return 3'b100;
    else if (r == 0)   return 3'b010;
    else               return 3'b001;
  endfunction

  // The ALU the controller drives
  always_comb begin
    aluRes = aluCalc(aluA, aluB, aluOp);
    {aluN, aluZ, aluP} = nzpOf(aluRes);
  end

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // CMP Rn,Rn: exposes R[n] on alu_a during EXEC
  function automatic logic [15:0] mkCmp(input logic [2:0] n);
    return {4'h4, 3'd0, n, 1'b0, 2'b00, n};
  endfunction

  // Monitor: in EXEC (not ready, not halted) pop and compare the ALU drive;
  // while idle the ALU ports must rest at zero
  always @(negedge clk) begin
    if (!rst && !instrReady && !haltedOut) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_underflow", 16'd1, 16'd0);
      end else begin
        monEntry = sbQ.pop_front();
        if (monEntry.chk) begin
          checkOutput("alu_a", aluA, monEntry.a);
          checkOutput("alu_b", aluB, monEntry.b);
          checkOutput("alu_op", {12'd0, aluOp}, {12'd0, monEntry.op});
        end
      end
    end else if (!rst && instrReady) begin
      checkOutput("alu_idle", aluA | aluB | {12'd0, aluOp}, 16'd0);
    end
  end

  // Reset the DUT and the reference model
  task automatic doReset();
    rst        = 1'b1;
    instrValid = 1'b0;
    instrWord  = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) modelR[i] = 16'h0000;
    modelPc = 16'h0000;
    modelCc = 3'b010;
    sbQ.delete();
  endtask

  // Reference model: queue expected ALU drive, advance model state
  task automatic modelStep(input logic [15:0] ins, output logic expIll, output logic expHalt);
    sbEntry_t    e;
    logic [3:0]  opc;
    logic [15:0] bv;
    logic [15:0] res;
    opc     = ins[15:12];
    bv      = ins[5] ? {{11{ins[4]}}, ins[4:0]} : modelR[ins[2:0]];
    expIll  = 1'b0;
    expHalt = 1'b0;
    e.chk = 1'b0; e.a = 16'h0; e.b = 16'h0; e.op = 4'h0;
    if (opc <= 4'h4) begin
      e.chk = 1'b1; e.a = modelR[ins[8:6]]; e.b = bv; e.op = opc;
      res = aluCalc(e.a, e.b, opc);
      if (opc != 4'h4) modelR[ins[11:9]] = res;
      modelCc = nzpOf(res);
      modelPc = modelPc + 16'd1;
    end else if (opc == 4'h5) begin
      e.chk = 1'b1; e.a = 16'h0; e.b = {{7{ins[8]}}, ins[8:0]}; e.op = 4'h0;
      res = e.b;
      modelR[ins[11:9]] = res;
      modelCc = nzpOf(res);
      modelPc = modelPc + 16'd1;
    end else if (opc == 4'h6) begin
      if ((ins[11:9] & modelCc) != 3'b000) modelPc = modelPc + 16'd1 + {{7{ins[8]}}, ins[8:0]};
      else modelPc = modelPc + 16'd1;
    end else if (opc == 4'h7) begin
      expHalt = 1'b1;
    end else begin
      expIll  = 1'b1;
      modelPc = modelPc + 16'd1;
    end
    sbQ.push_back(e);
  endtask

  // Issue one instruction, keeping valid high through EXEC to show it is
  // ignored while not ready, then check the committed state
  task automatic applyStimulus(input logic [15:0] ins);
    int   waitCnt;
    logic expIll;
    logic expHalt;
    waitCnt = 0;
    @(negedge clk);
    while (!instrReady && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!instrReady) begin
      checkOutput("ready_timeout", 16'd0, 16'd1);
      return;
    end
    modelStep(ins, expIll, expHalt);
    instrValid = 1'b1;
    instrWord  = ins;
    @(posedge clk);
    #1 checkOutput("busy_in_exec", {15'd0, instrReady}, 16'd0);
    @(posedge clk);
    #1;
    instrValid = 1'b0;
    checkOutput("pc", pcOut, modelPc);
    checkOutput("cc", {13'd0, ccOut}, {13'd0, modelCc});
    checkOutput("illegal", {15'd0, illegalOut}, {15'd0, expIll});
    checkOutput("halted", {15'd0, haltedOut}, {15'd0, expHalt});
    checkOutput("ready_after", {15'd0, instrReady}, {15'd0, !expHalt});
  endtask

  // Main sequence
  initial begin
    rst        = 1'b1;
    instrValid = 1'b0;
    instrWord  = 16'h0000;
    doReset();
    @(negedge clk);
    checkOutput("rst_pc", pcOut, 16'h0000);
    checkOutput("rst_cc", {13'd0, ccOut}, 16'h0002);
    checkOutput("rst_ready", {15'd0, instrReady}, 16'd1);
    checkOutput("rst_illegal", {15'd0, illegalOut}, 16'd0);
    checkOutput("rst_halted", {15'd0, haltedOut}, 16'd0);

    // LDI R1,#10; LDI R2,#5; ADD R3,R1,R2
    applyStimulus(16'h520A);
    applyStimulus(16'h5405);
    applyStimulus(16'h0642);
    checkOutput("add_pc3", pcOut, 16'd3);
    checkOutput("add_cc_p", {13'd0, ccOut}, 16'h0001);
    applyStimulus(mkCmp(3'd3));

    // LDI R1,#3; SUB R4,R1,#7; CMP R1,R1; read back R4
    applyStimulus(16'h5203);
    applyStimulus(16'h1867);
    checkOutput("sub_cc_n", {13'd0, ccOut}, 16'h0004);
    applyStimulus(mkCmp(3'd1));
    checkOutput("cmp_cc_z", {13'd0, ccOut}, 16'h0002);
    applyStimulus(mkCmp(3'd4));

    // Branches from pc=8 with cc=Z, then wrap through 16'hFFFF
    checkOutput("br_start_pc", pcOut, 16'd8);
    applyStimulus(16'h65FE);
    checkOutput("br_taken_pc", pcOut, 16'd7);
    applyStimulus(mkCmp(3'd1));
    applyStimulus(16'h63FE);
    checkOutput("br_not_taken_pc", pcOut, 16'd9);
    applyStimulus(16'h65F5);
    checkOutput("br_to_ffff", pcOut, 16'hFFFF);
    applyStimulus(16'h63FE);
    checkOutput("pc_wrap", pcOut, 16'h0000);

    // Undefined opcode: single-cycle pulse, pc advances, cc kept
    applyStimulus(16'hA123);
    @(posedge clk);
    #1 checkOutput("illegal_one_cycle", {15'd0, illegalOut}, 16'd0);
    checkOutput("illegal_cc", {13'd0, ccOut}, 16'h0002);
    checkOutput("illegal_pc", pcOut, 16'd1);
    for (int n = 0; n < 8; n++) applyStimulus(mkCmp(n[2:0]));

    // HALT: ready stays low with valid held high, reset recovers
    applyStimulus(16'h7000);
    instrValid = 1'b1;
    instrWord  = 16'h5E01;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 checkOutput("halt_ready_low", {15'd0, instrReady}, 16'd0);
    end
    doReset();
    @(negedge clk);
    checkOutput("halt_rst_pc", pcOut, 16'h0000);
    checkOutput("halt_rst_halted", {15'd0, haltedOut}, 16'd0);
    checkOutput("halt_rst_cc", {13'd0, ccOut}, 16'h0002);

    // Reset during EXEC of ADD R5,R1,#1 discards it
    applyStimulus(16'h5204);
    @(negedge clk);
    begin
      logic dIll, dHalt;
      modelStep(16'h0A61, dIll, dHalt);
    end
    instrValid = 1'b1;
    instrWord  = 16'h0A61;
    @(posedge clk);
    #1 instrValid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) modelR[i] = 16'h0000;
    modelPc = 16'h0000;
    modelCc = 3'b010;
    checkOutput("abort_pc", pcOut, 16'h0000);
    checkOutput("abort_cc", {13'd0, ccOut}, 16'h0002);
    applyStimulus(mkCmp(3'd5));

    repeat (2) @(posedge clk);
    checkOutput("sb_empty", sbQ.size(), 16'd0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
